// File: rtl/axis_up_sched.sv
// axis_up_sched: upstream packet scheduler for the AXI-Stream switch.
// Arbitrates user project (0), axilite-axis bridge (1) and logic analyzer (2)
// onto the single IO-serdes output with a registered one-hot grant that is
// held for a whole packet or, for normal grants, up to burst_limit beats.
// Optional feature: define AXIS_SCHED_STARVE_EN to bound how many
// consecutive high-priority grants may pass a waiting normal request.
module axis_up_sched #(
  parameter int              PORTS        = 3,
  parameter logic [PORTS-1:0] HI_MASK     = 3'b101,
  parameter int              BURST_W      = 3,
  parameter int              STARVE_LIMIT = 4
) (
  input  logic               axis_clk,
  input  logic               axi_reset_n,
  input  logic [PORTS-1:0]   req,
  input  logic [PORTS-1:0]   hi_req,
  input  logic               beat,
  input  logic               last,
  input  logic [BURST_W-1:0] burst_limit,
  output logic [PORTS-1:0]   grant,
  output logic [1:0]         grant_id,
  output logic               grant_hi,
  output logic               busy
);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  logic               state;
  logic [1:0]         last_id;
  logic [BURST_W-1:0] beat_cnt;

  logic [PORTS-1:0]   hi_set;
  logic [PORTS-1:0]   hi_eff;
  logic [PORTS-1:0]   rr_pool;
  logic               pick_valid;
  logic               pick_hi;
  logic [1:0]         pick_id;
  int                 rr_idx;
  logic               burst_end;
  logic               release_now;

  assign hi_set = req & hi_req & HI_MASK;
  assign busy   = (state == ST_GRANT);

`ifdef AXIS_SCHED_STARVE_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_cnt;
  logic          starving;

  // Once the guard trips, high priority is ignored and the round-robin pool is
  // narrowed to the sources that were actually waiting behind it.
  always_comb begin
    starving = (starve_cnt == SW'(STARVE_LIMIT));
    hi_eff   = hi_set;
    rr_pool  = req;
    if (starving) begin
      hi_eff = '0;
      if ((req & ~hi_set) != '0) rr_pool = req & ~hi_set;
    end
  end
`else
  // Without the guard high priority always wins.
  always_comb begin
    hi_eff  = hi_set;
    rr_pool = req;
  end
`endif

  // Pick the next owner: lowest eligible hi index, else round-robin after last_id.
  always_comb begin
    pick_valid = 1'b0;
    pick_hi    = 1'b0;
    pick_id    = 2'd0;
    rr_idx     = 0;
    if (hi_eff != '0) begin
      pick_valid = 1'b1;
      pick_hi    = 1'b1;
      for (int i = PORTS - 1; i >= 0; i--) begin
        if (hi_eff[i]) pick_id = 2'(i);
      end
    end else if (rr_pool != '0) begin
      pick_valid = 1'b1;
      for (int k = PORTS; k >= 1; k--) begin
        rr_idx = (int'(last_id) + k) % PORTS;
        if (rr_pool[rr_idx]) pick_id = 2'(rr_idx);
      end
    end
  end

  // Release on packet end, or on the last beat of a burst for normal grants.
  always_comb begin
    burst_end   = !grant_hi && (burst_limit != '0) &&
                  (beat_cnt == (burst_limit - BURST_W'(1)));
    release_now = beat && (last || burst_end);
  end

  // Grant state machine; arbitration happens only while idle.
  always_ff @(posedge axis_clk) begin
    if (!axi_reset_n) begin
      state    <= ST_IDLE;
      grant    <= '0;
      grant_id <= 2'd0;
      grant_hi <= 1'b0;
      last_id  <= 2'(PORTS - 1);
      beat_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            state    <= ST_GRANT;
            grant    <= PORTS'(1) << pick_id;
            grant_id <= pick_id;
            grant_hi <= pick_hi;
            beat_cnt <= '0;
            if (!pick_hi) last_id <= pick_id;
          end
        end
        default: begin
          if (release_now) begin
            state    <= ST_IDLE;
            grant    <= '0;
            grant_id <= 2'd0;
            grant_hi <= 1'b0;
          end else if (beat && (beat_cnt != '1)) begin
            beat_cnt <= beat_cnt + BURST_W'(1);
          end
        end
      endcase
    end
  end

`ifdef AXIS_SCHED_STARVE_EN
  // Count hi grants that bypass a waiting normal source; any normal grant clears.
  always_ff @(posedge axis_clk) begin
    if (!axi_reset_n) begin
      starve_cnt <= '0;
    end else if ((state == ST_IDLE) && pick_valid) begin
      if (!pick_hi) begin
        starve_cnt <= '0;
      end else if (((req & ~hi_set) != '0) && !starving) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_axis_up_sched.sv
// Testbench for axis_up_sched: directed scenarios plus a randomized run, all
// checked against a beat-counting reference model of the scheduling rules.
module tb_axis_up_sched;

  localparam logic [2:0] HI_MASK      = 3'b101;
  localparam int         STARVE_LIMIT = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] req;
  logic [2:0] hi_req;
  logic       beat;
  logic       last;
  logic [2:0] burst_limit;
  logic [2:0] grant;
  logic [1:0] grant_id;
  logic       grant_hi;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: owner, whether hi, last normal owner, beats taken so far.
  int m_busy, m_idx, m_hi, m_last, m_beats;
`ifdef AXIS_SCHED_STARVE_EN
  int m_starve;
`endif

  axis_up_sched #(
    .PORTS(3), .HI_MASK(HI_MASK), .BURST_W(3), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .axis_clk(clk), .axi_reset_n(rst_n), .req(req), .hi_req(hi_req),
    .beat(beat), .last(last), .burst_limit(burst_limit),
    .grant(grant), .grant_id(grant_id), .grant_hi(grant_hi), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] exp_grant();
    return m_busy ? 3'(1 << m_idx) : 3'b000;
  endfunction

  task automatic model_edge();
    logic [2:0] h, normals, pool;
    bit use_hi;
    if (!rst_n) begin
      m_busy = 0; m_idx = 0; m_hi = 0; m_last = 2; m_beats = 0;
`ifdef AXIS_SCHED_STARVE_EN
      m_starve = 0;
`endif
    end else if (m_busy == 0) begin
      h       = req & hi_req & HI_MASK;
      normals = req & ~h;
      use_hi  = (h != 3'b000);
      pool    = req;
`ifdef AXIS_SCHED_STARVE_EN
      if (m_starve == STARVE_LIMIT) begin
        use_hi = 0;
        if (normals != 3'b000) pool = normals;
      end
`endif
      if (use_hi) begin
        for (int i = 0; i < 3; i++) if (h[i]) begin m_idx = i; break; end
        m_hi = 1; m_busy = 1; m_beats = 0;
`ifdef AXIS_SCHED_STARVE_EN
        if (normals != 3'b000 && m_starve < STARVE_LIMIT) m_starve++;
`endif
      end else if (pool != 3'b000) begin
        for (int k = 1; k <= 3; k++) begin
          if (pool[(m_last + k) % 3]) begin m_idx = (m_last + k) % 3; break; end
        end
        m_last = m_idx; m_hi = 0; m_busy = 1; m_beats = 0;
`ifdef AXIS_SCHED_STARVE_EN
        m_starve = 0;
`endif
      end
    end else if (beat) begin
      m_beats++;
      if (last || (m_hi == 0 && burst_limit != 0 && m_beats == int'(burst_limit))) begin
        m_busy = 0; m_idx = 0; m_hi = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drain();
    req = 3'b000; hi_req = 3'b000; beat = 1'b1; last = 1'b1;
    tick();
    beat = 1'b0; last = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 3'b000; hi_req = 3'b000; beat = 1'b0; last = 1'b0;
    burst_limit = 3'd0;
    tick(); tick();
    n_cmp++; if (grant !== 3'b000) begin n_err++; $display("[TB] FAIL reset_grant: got %b want 000", grant); end
    n_cmp++; if (grant_id !== 2'd0) begin n_err++; $display("[TB] FAIL reset_grant_id: got %0d want 0", grant_id); end
    n_cmp++; if (grant_hi !== 1'b0) begin n_err++; $display("[TB] FAIL reset_grant_hi: got %b want 0", grant_hi); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_first_grant();
    rst_n = 1'b1; req = 3'b111;
    tick();
    n_cmp++; if (grant !== 3'b001) begin n_err++; $display("[TB] FAIL first_grant: got %b want 001", grant); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("[TB] FAIL first_busy: got %b want 1", busy); end
    beat = 1'b1; last = 1'b1;
    tick();
    n_cmp++; if (grant !== 3'b000) begin n_err++; $display("[TB] FAIL first_bubble: got %b want 000", grant); end
    beat = 1'b0; last = 1'b0;
    tick();
    n_cmp++; if (grant !== 3'b010) begin n_err++; $display("[TB] FAIL second_grant: got %b want 010", grant); end
    n_cmp++; if (grant_id !== 2'd1) begin n_err++; $display("[TB] FAIL second_grant_id: got %0d want 1", grant_id); end
    drain();
  endtask

  task automatic test_round_robin();
    logic [2:0] seq [7] = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    req = 3'b111; burst_limit = 3'd0; beat = 1'b1; last = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      n_cmp++;
      if (grant !== seq[i]) begin n_err++; $display("[TB] FAIL rr_step%0d: got %b want %b", i, grant, seq[i]); end
    end
    drain();
  endtask

  task automatic test_burst_limit();
    logic [2:0] seq [5] = '{3'b010, 3'b010, 3'b010, 3'b000, 3'b010};
    req = 3'b010; burst_limit = 3'd3; beat = 1'b1; last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (grant !== seq[i]) begin n_err++; $display("[TB] FAIL burst_step%0d: got %b want %b", i, grant, seq[i]); end
    end
    burst_limit = 3'd0;
    drain();
  endtask

  task automatic test_high_priority();
    req = 3'b111; hi_req = 3'b111; beat = 1'b0; last = 1'b0;
    tick();
    n_cmp++; if (grant !== 3'b001) begin n_err++; $display("[TB] FAIL hi_all_grant: got %b want 001", grant); end
    n_cmp++; if (grant_hi !== 1'b1) begin n_err++; $display("[TB] FAIL hi_all_flag: got %b want 1", grant_hi); end
    beat = 1'b1; last = 1'b1;
    tick();
    beat = 1'b0; last = 1'b0; hi_req = 3'b100; burst_limit = 3'd2;
    tick();
    n_cmp++; if (grant !== 3'b100) begin n_err++; $display("[TB] FAIL hi_la_grant: got %b want 100", grant); end
    n_cmp++; if (grant_id !== 2'd2) begin n_err++; $display("[TB] FAIL hi_la_id: got %0d want 2", grant_id); end
    beat = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (grant !== 3'b100) begin n_err++; $display("[TB] FAIL hi_hold_beat%0d: got %b want 100", i + 1, grant); end
    end
    last = 1'b1;
    tick();
    n_cmp++; if (grant !== 3'b000) begin n_err++; $display("[TB] FAIL hi_release: got %b want 000", grant); end
    burst_limit = 3'd0;
    drain();
  endtask

  task automatic test_no_preempt_reset();
    logic pat [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    req = 3'b010; hi_req = 3'b000; beat = 1'b0; last = 1'b0;
    tick();
    n_cmp++; if (grant !== 3'b010) begin n_err++; $display("[TB] FAIL np_grant: got %b want 010", grant); end
    req = 3'b011; hi_req = 3'b001;
    for (int i = 0; i < 4; i++) begin
      beat = pat[i];
      tick();
      n_cmp++;
      if (grant !== 3'b010 || grant_hi !== 1'b0) begin
        n_err++; $display("[TB] FAIL np_hold%0d: got %b/%b want 010/0", i, grant, grant_hi);
      end
    end
    beat = 1'b1; last = 1'b1;
    tick();
    n_cmp++; if (grant !== 3'b000) begin n_err++; $display("[TB] FAIL np_release: got %b want 000", grant); end
    beat = 1'b0; last = 1'b0;
    tick();
    n_cmp++; if (grant !== 3'b001 || grant_hi !== 1'b1) begin n_err++; $display("[TB] FAIL np_next_hi: got %b/%b want 001/1", grant, grant_hi); end
    beat = 1'b1; rst_n = 1'b0;
    tick();
    n_cmp++; if (grant !== 3'b000 || busy !== 1'b0) begin n_err++; $display("[TB] FAIL abort: got %b/%b want 000/0", grant, busy); end
    rst_n = 1'b1;
    drain();
  endtask

  task automatic test_starvation();
`ifdef AXIS_SCHED_STARVE_EN
    logic [2:0] want [6] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b001};
`else
    logic [2:0] want [6] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`endif
    req = 3'b011; hi_req = 3'b001; beat = 1'b1; last = 1'b1; burst_limit = 3'd0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++;
      if (grant !== want[i] || grant_hi !== (want[i] == 3'b001)) begin
        n_err++; $display("[TB] FAIL starve_grant%0d: got %b/%b want %b", i, grant, grant_hi, want[i]);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst_n  = ($urandom_range(63) != 0);
      req    = 3'($urandom);
      hi_req = ($urandom_range(2) == 0) ? 3'($urandom) : 3'b000;
      beat   = (m_busy != 0) && ($urandom_range(3) != 0);
      last   = ($urandom_range(4) == 0);
      if (m_busy == 0 && $urandom_range(7) == 0) burst_limit = 3'($urandom);
      tick();
      n_cmp++;
      if (grant !== exp_grant() || grant_id !== 2'(m_idx) || grant_hi !== m_hi[0] || busy !== m_busy[0]) begin
        n_err++;
        $display("[TB] FAIL random_cycle%0d: got g=%b id=%0d hi=%b busy=%b want g=%b id=%0d hi=%0d busy=%0d",
                 i, grant, grant_id, grant_hi, busy, exp_grant(), m_idx, m_hi, m_busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_grant();
    test_round_robin();
    test_burst_limit();
    test_high_priority();
    test_no_preempt_reset();
    test_starvation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axis_up_sched.md
# axis_up_sched

Upstream packet scheduler for the AXI-Stream switch. It arbitrates the three upstream sources (user project, axilite-axis bridge, logic analyzer) onto the single IO-serdes output. It issues a registered one-hot grant and holds it for a whole packet or a configurable burst. The switch uses the grant to steer the mux, drive per-source tready and tag tid.

## Interface
- PORTS, 3, number of upstream requesters; index 0 = user project, 1 = axilite-axis, 2 = logic analyzer
- HI_MASK, 3'b101, requesters allowed to use hi_req; bits at 0 ignore hi_req
- BURST_W, 3, width of the burst counter and burst_limit
- STARVE_LIMIT, 4, consecutive hi grants tolerated while a normal request waits (used only with the macro)
- axis_clk  in  1  clock
- axi_reset_n  in  1  synchronous active-low reset, sampled on rising axis_clk
- req  in  PORTS  per-source tvalid
- hi_req  in  PORTS  per-source high-priority request, qualified by HI_MASK
- beat  in  1  output beat accepted (as_is_tvalid & is_as_tready)
- last  in  1  tlast of the accepted beat
- burst_limit  in  BURST_W  maximum beats per normal grant; 0 = unlimited
- grant  out  PORTS  registered one-hot grant; all zero when idle
- grant_id  out  2  binary index of grant; 0 when idle
- grant_hi  out  1  current grant was issued as high priority
- busy  out  1  state == GRANT

## Operation
- States: IDLE, GRANT.
- **IDLE, arbitration.** Arbitration runs only in IDLE.
  - Eligible high set: H = req & hi_req & HI_MASK.
  - If H ≠ 0, grant the lowest set index of H and set grant_hi = 1.
  - Otherwise, if req ≠ 0, run round-robin. Search starts at (last_id+1) mod PORTS, wraps, and grants the first set req. Set grant_hi = 0.
  - last_id updates only on normal grants, so hi grants do not disturb round-robin fairness.
  - If req == 0, stay in IDLE with grant = 0.
- **GRANT.**
  - The grant is held regardless of req or hi_req changes. There is no preemption. A tvalid gap inside a packet does not release the grant.
  - beat_cnt increments on each beat. It resets to 0 on entry to GRANT.
- **Release: GRANT -> IDLE at the end of a cycle where either:**
  - beat & last; or
  - grant_hi = 0, burst_limit ≠ 0, and beat with beat_cnt == burst_limit-1.
  - Hi grants ignore burst_limit and release only on last.
- **Counter width.** beat_cnt is BURST_W bits wide and saturates at all-ones. With burst_limit = 0 it never forces a release.
- **PORTS.** Only values up to 4 are supported (grant_id width).

## Timing
- **Reset.** While axi_reset_n is low at a rising edge, the next state is:
  - state = IDLE, grant = 0, grant_id = 0, grant_hi = 0, busy = 0;
  - last_id = PORTS-1, so the first round-robin grant goes to index 0;
  - beat_cnt = 0, starve_cnt = 0.
- **Reset mid-packet.** Reset asserted mid-packet drops the grant on the next edge. No release condition is evaluated.
- **Grant latency.** A req sampled in IDLE at edge N gives grant valid after edge N. The switch may then forward beats in that same cycle.
- **Release to next grant.** A release at edge N gives grant = 0 for cycle N..N+1. The next grant appears after edge N+1, so there is exactly one bubble cycle between grants.
- **Single-beat packet.** beat & last on the first granted cycle releases at that edge.
- **Simultaneous events.**
  - hi_req rising during a normal grant takes effect only at the next IDLE.
  - A release and a new req in the same cycle are handled per the bubble rule.
- **Outputs.** All outputs are flops. There is no combinational path from req or beat to grant.

## Configuration
- **Macro AXIS_SCHED_STARVE_EN.**
  - **Defined.** starve_cnt (width $clog2(STARVE_LIMIT+1)) is maintained as follows:
    - It increments on each hi grant issued while (req & ~H) ≠ 0.
    - It clears on any normal grant.
    - When starve_cnt == STARVE_LIMIT, the next arbitration treats H as 0 and uses round-robin; that normal grant clears the counter.
  - **Undefined.** starve_cnt is absent and hi_req always wins, so normal sources may starve indefinitely.

## Test plan
- **Reset and first grant.** Reset, then req=3'b111, hi_req=0 -> grant=001 one cycle later. A beat with last -> grant=000 for one cycle, then 010.
- **Round-robin order.** req held at 3'b111, burst_limit=0, single-beat packets -> grant sequence 001, 010, 100, 001, with a bubble between each.
- **Burst limit.** req=3'b010 only, burst_limit=3, continuous beats with last=0 -> grant=010 released after the 3rd beat (beat_cnt==2). Then 1 idle cycle, then 010 re-granted.
- **High priority.**
  - req=3'b111, hi_req=3'b111 -> grant=001 with grant_hi=1 (bit 1 masked by HI_MASK).
  - hi_req=3'b100 -> grant=100.
  - A hi grant with burst_limit=2 holds for 5 beats until last.
- **No preemption and reset abort.**
  - During a normal 010 grant, assert hi_req[0] -> grant stays 010 until last.
  - Assert axi_reset_n=0 mid-packet -> grant=0 and busy=0 after the next edge.
- **Starvation guard (AXIS_SCHED_STARVE_EN).** req=3'b011, hi_req=3'b001, STARVE_LIMIT=4 -> four 001 hi grants, then the fifth grant is 010 with grant_hi=0. Without the macro, 001 repeats indefinitely.
